// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : systolic_ctrl
// Purpose : Control/address sequencer for an NxN weight-stationary systolic
//           array tile: weight load, skewed activation stream, output strobes.
// Rev     : 1.0
// ============================================================================
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int VEC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_W-1:0]     num_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [$clog2(N)-1:0] w_rd_addr,
  output logic                 weight_en,
  output logic                 a_rd_en,
  output logic [VEC_W-1:0]     a_rd_addr,
  output logic [N-1:0]         a_row_en,
  output logic [N-1:0]         out_valid
);

  localparam int AW = $clog2(N);
  localparam int CW = VEC_W + 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_W_TAIL = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [VEC_W-1:0] r_m;

  logic             r_busy, r_done, r_w_rd_en, r_weight_en, r_a_rd_en;
  logic [AW-1:0]    r_w_rd_addr;
  logic [VEC_W-1:0] r_a_rd_addr;
  logic [N-1:0]     r_a_row_en, r_out_valid;

  logic             w_idle, w_take, w_run;
  logic [VEC_W-1:0] w_m;
  logic [CW-1:0]    w_mx, w_n, w_last;
  logic             w_busy_nxt, w_done_nxt, w_wen_nxt, w_wten_nxt, w_aen_nxt;
  logic [AW-1:0]    w_waddr_nxt;
  logic [VEC_W-1:0] w_aaddr_nxt;
  logic [N-1:0]     w_row_nxt, w_ov_nxt;

  function automatic logic f_in_win(input logic [CW-1:0] n,
                                    input logic [CW-1:0] lo,
                                    input logic [CW-1:0] len);
    return (n >= lo) && (n < lo + len);
  endfunction

  // w_n is the tile cycle index the registered outputs will present next.
  always_comb begin
    w_idle = (r_state == S_IDLE);
    w_take = w_idle && start;
    w_m    = w_take ? num_vec : r_m;
    w_mx   = {6'd0, w_m};
    w_n    = w_idle ? CW'(1) : r_cnt + CW'(1);
    w_last = CW'(3*N+3) + w_mx;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_take && (num_vec != '0)) w_state_nxt = S_LOAD_W;
      S_LOAD_W: if (w_n == CW'(N+1)) w_state_nxt = S_W_TAIL;
      S_W_TAIL: w_state_nxt = S_STREAM;
      S_STREAM: if (w_n == CW'(N+2) + w_mx) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_cnt == w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_run      = (w_state_nxt != S_IDLE);
    w_busy_nxt = w_run && (w_n != w_last);
    w_done_nxt = (w_run && (w_n == w_last)) || (w_take && (num_vec == '0));
    w_wen_nxt  = w_run && f_in_win(w_n, CW'(1), CW'(N));
    w_wten_nxt = w_run && f_in_win(w_n, CW'(2), CW'(N));
    w_aen_nxt  = w_run && f_in_win(w_n, CW'(N+2), w_mx);

    w_waddr_nxt = '0;
    if (w_wen_nxt)
      w_waddr_nxt = (w_n == CW'(1)) ? AW'(N-1) : r_w_rd_addr - AW'(1);

    w_aaddr_nxt = '0;
    if (w_aen_nxt)
      w_aaddr_nxt = r_a_rd_en ? r_a_rd_addr + VEC_W'(1) : '0;

    w_row_nxt = '0;
    w_ov_nxt  = '0;
    for (int r = 0; r < N; r++) begin
      w_row_nxt[r] = w_run && f_in_win(w_n, CW'(N+3+r), w_mx);
      w_ov_nxt[r]  = w_run && f_in_win(w_n, CW'(2*N+4+r), w_mx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_m         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_weight_en <= 1'b0;
      r_a_rd_en   <= 1'b0;
      r_a_rd_addr <= '0;
      r_a_row_en  <= '0;
      r_out_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_run ? w_n : '0;
      r_m         <= w_m;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_w_rd_en   <= w_wen_nxt;
      r_w_rd_addr <= w_waddr_nxt;
      r_weight_en <= w_wten_nxt;
      r_a_rd_en   <= w_aen_nxt;
      r_a_rd_addr <= w_aaddr_nxt;
      r_a_row_en  <= w_row_nxt;
      r_out_valid <= w_ov_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign w_rd_en   = r_w_rd_en;
  assign w_rd_addr = r_w_rd_addr;
  assign weight_en = r_weight_en;
  assign a_rd_en   = r_a_rd_en;
  assign a_rd_addr = r_a_rd_addr;
  assign a_row_en  = r_a_row_en;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_ctrl
// Purpose : Self-checking bench for systolic_ctrl with a cycle-window model and
//           a behavioural array scoreboard driven by the controller strobes.
// Rev     : 1.0
// ============================================================================
module tb_systolic_ctrl;

  localparam int N     = 4;
  localparam int VEC_W = 16;
  localparam int AW    = $clog2(N);
  localparam int ONE_Q = 32'h0200_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] num_vec;
  logic             busy, done, w_rd_en, weight_en, a_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic [VEC_W-1:0] a_rd_addr;
  logic [N-1:0]     a_row_en, out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  int     wbuf  [N][N];
  int     chain [N][N];
  int     w_q   [N];
  int     abuf  [512][N];
  longint psum  [512][N];
  int     rd_log[$];
  int     row_cnt[N];
  int     col_cnt[N];

  systolic_ctrl #(.N(N), .VEC_W(VEC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .weight_en (weight_en),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .a_row_en  (a_row_en),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, obs, exp);
    end
  endtask

  // Expected control outputs in tile cycle k for a tile of m vectors (k=0: idle),
  // then advance the array model by one clock using the observed strobes.
  task automatic step(input int k, input int m);
    int last;
    int j;
    int x;
    logic [N-1:0] e_row, e_ov;
    last = 3*N + 3 + m;
    chk("busy", k, 64'(busy), 64'((m > 0) && (k >= 1) && (k < last)));
    chk("done", k, 64'(done), 64'((m == 0) ? (k == 1) : (k == last)));
    chk("w_rd_en", k, 64'(w_rd_en), 64'((m > 0) && (k >= 1) && (k <= N)));
    if ((m > 0) && (k >= 1) && (k <= N))
      chk("w_rd_addr", k, 64'(w_rd_addr), 64'(N - k));
    chk("weight_en", k, 64'(weight_en), 64'((m > 0) && (k >= 2) && (k <= N+1)));
    chk("a_rd_en", k, 64'(a_rd_en), 64'((k >= N+2) && (k <= N+1+m)));
    if ((k >= N+2) && (k <= N+1+m))
      chk("a_rd_addr", k, 64'(a_rd_addr), 64'(k - N - 2));
    for (int r = 0; r < N; r++) begin
      e_row[r] = (k >= N+3+r) && (k <= N+2+r+m);
      e_ov[r]  = (k >= 2*N+4+r) && (k <= 2*N+3+r+m);
    end
    chk("a_row_en", k, 64'(a_row_en), 64'(e_row));
    chk("out_valid", k, 64'(out_valid), 64'(e_ov));

    // Array model: column results must equal the identity-weighted inputs.
    for (int c = 0; c < N; c++) begin
      if (out_valid[c]) begin
        j = col_cnt[c];
        col_cnt[c]++;
        if ((j < 512) && (j < rd_log.size()) && (rd_log[j] < 512))
          chk("col_data", k, 64'(psum[j][c]), 64'(longint'(abuf[rd_log[j]][c])));
      end
    end
    for (int r = 0; r < N; r++) begin
      if (a_row_en[r]) begin
        j = row_cnt[r];
        row_cnt[r]++;
        if ((j < 512) && (j < rd_log.size()) && (rd_log[j] < 512)) begin
          x = abuf[rd_log[j]][r];
          for (int c = 0; c < N; c++)
            psum[j][c] += (longint'(chain[r][c]) * longint'(x)) >>> 25;
        end
      end
    end
    if (a_rd_en) rd_log.push_back(int'(a_rd_addr));
    if (weight_en) begin
      for (int r = N-1; r > 0; r--) chain[r] = chain[r-1];
      chain[0] = w_q;
    end
    if (w_rd_en) w_q = wbuf[w_rd_addr];
  endtask

  // Runs one tile from a start in the current cycle. Extra start pulses at
  // cycles pa/pb must be ignored; rst_at > 0 aborts the tile with a reset.
  task automatic run_tile(input int m, input int pa, input int pb, input int rst_at);
    int last;
    last = (m == 0) ? 1 : 3*N + 3 + m;
    rd_log.delete();
    for (int i = 0; i < N; i++) begin
      row_cnt[i] = 0;
      col_cnt[i] = 0;
    end
    for (int i = 0; i < 512; i++)
      for (int c = 0; c < N; c++) psum[i][c] = 0;
    start   = 1'b1;
    num_vec = VEC_W'(m);
    tick;
    for (int k = 1; k <= last; k++) begin
      if (k == rst_at) begin
        start = 1'b0;
        rst   = 1'b0;
        #1;
        step(0, m);
        @(posedge clk);
        #1;
        step(0, m);
        rst = 1'b1;
        return;
      end
      start   = (k == pa) || (k == pb);
      num_vec = VEC_W'($urandom);
      step(k, m);
      tick;
    end
    start = 1'b0;
    step(last + 1, m);
    for (int c = 0; c < N; c++)
      chk("ov_count", last, 64'(col_cnt[c]), 64'(m));
    chk("rd_count", last, 64'(rd_log.size()), 64'(m));
  endtask

  initial begin
    int m, pa, gap;
    for (int r = 0; r < N; r++) begin
      w_q[r] = 0;
      for (int c = 0; c < N; c++) begin
        wbuf[r][c]  = (r == c) ? ONE_Q : 0;
        chain[r][c] = 0;
      end
    end
    for (int i = 0; i < 512; i++)
      for (int c = 0; c < N; c++) abuf[i][c] = int'($urandom);
    for (int c = 0; c < N; c++) begin
      abuf[0][c] = (c + 1) * ONE_Q;
      abuf[1][c] = (c + 5) * ONE_Q;
    end

    rst     = 1'b0;
    start   = 1'b0;
    num_vec = '0;
    tick;
    step(0, 0);
    tick;
    rst = 1'b1;
    step(0, 0);

    // End-to-end identity tile, M=2.
    run_tile(2, 0, 0, 0);
    // M=3 with ignored starts in cycles 5 and 18, then a start in cycle 19.
    run_tile(3, 5, 18, 0);
    run_tile(1, 0, 0, 0);
    // Empty tile.
    run_tile(0, 0, 0, 0);
    tick;
    step(0, 0);
    // Reset in cycle 9, then a fresh M=1 tile right after release.
    run_tile(3, 0, 0, 9);
    run_tile(1, 0, 0, 0);
    // Wide tile.
    run_tile(300, 0, 0, 0);

    // Random tiles with random idle gaps and stray start pulses.
    repeat (8) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        tick;
        step(0, 0);
      end
      m  = $urandom_range(0, 24);
      pa = (m > 0) ? $urandom_range(1, 3*N + 3 + m) : 0;
      run_tile(m, pa, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the N×N weight-stationary systolic array of 32-bit Q7.25 processing elements. On a `start` pulse it loads one weight tile from the weight buffer into the array, streams `num_vec` activation vectors from the activation buffer into row 0, generates the per-row skew enables and per-column output-valid strobes, then signals completion. It sits between the tile scheduler (start/done) and the array plus its input and output buffers. It moves no data itself; it only drives control and addresses.

## Interface
- `N`, 4: array dimension, number of rows and columns (2..16).
- `VEC_W`, 16: width of the vector count and the activation address.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run one tile. Sampled only in IDLE.
- `num_vec`  in  VEC_W  number of activation vectors M. Latched when `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the tile is finished.
- `w_rd_en`  out  1  weight buffer read strobe. Read latency is 1 cycle.
- `w_rd_addr`  out  clog2(N)  weight row address.
- `weight_en`  out  1  drives the weight_en pin of every PE (shifts the vertical weight chain).
- `a_rd_en`  out  1  activation buffer read strobe. Read latency is 1 cycle.
- `a_rd_addr`  out  VEC_W  activation vector index.
- `a_row_en`  out  N  bit r high means row r's skewed activation input is valid this cycle. The external mux forces row r to zero when its bit is low.
- `out_valid`  out  N  bit c high means the bottom-row partial sum of column c is a valid result this cycle.

## Operation
- States: IDLE → LOAD_W → W_TAIL → STREAM → DRAIN → IDLE.
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and all counters to 0.
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE. On that edge, M is latched and `busy` is set.
- **M = 0:** go directly to IDLE. `done` pulses in cycle 1, no reads are issued, and `busy` is never raised.
- **LOAD_W (cycles 1..N):**
  - `w_rd_en`=1.
  - `w_rd_addr` = N-1-k in cycle 1+k, so the bottom row is read first.
- **W_TAIL (cycle N+1):** single cycle.
- `weight_en` is `w_rd_en` delayed by one cycle, so it is high in cycles 2..N+1. After N shifts, row r holds buffer row r.
- **STREAM:**
  - `a_rd_en`=1 in cycles N+2 .. N+1+M.
  - `a_rd_addr` = t in cycle N+2+t.
  - Vector t reaches row 0's input in cycle N+3+t.
- **Row skew:** `a_row_en[r]` is high in cycles N+3+r .. N+2+r+M (a contiguous window of M cycles per row).
- **Column outputs:** `out_valid[c]` is high in cycles 2N+4+c .. 2N+3+c+M. In cycle 2N+4+c+t, column c carries the result for vector t.
- **DRAIN:** entered when `a_rd_en` falls. It lasts until the last `out_valid[N-1]` cycle, 3N+2+M.
- `done`=1 and `busy`=0 in cycle 3N+3+M, then the block returns to IDLE.
- A single free-running tile cycle counter (cleared at start) plus the latched M derive all windows. Counter width is VEC_W+6 bits. Comparisons are unsigned, with no wrap for M ≤ 2^VEC_W−1.

## Timing
- Total tile latency, `start` to `done`: 3N+3+M cycles.
- With N=4 and M=1, `done` is in cycle 16.
- `start` while `busy`: ignored. It is neither queued nor able to alter the latched M.
- `start` in the same cycle as `done`: ignored, because the state is not yet IDLE. A new tile can be accepted from the cycle after `done`.
- `num_vec` changing while busy has no effect.
- **Max M:** with M = 2^VEC_W−1, `a_rd_addr` reaches 2^VEC_W−2 and never wraps to 0.
- **Reset low mid-tile:** all outputs drop to 0 immediately (asynchronously), state goes to IDLE, and no `done` is issued.
- **Reset release:** the first `start` can be sampled on the first rising edge after `rst` is high.
- **Back-to-back tiles:** no weight/activation overlap. Each tile reloads its weights.

## Test plan
- **N=4, M=3, start in cycle 0:**
  - `w_rd_addr` = 3,2,1,0 in cycles 1–4.
  - `weight_en` high in cycles 2–5.
  - `a_rd_addr` = 0,1,2 in cycles 6–8.
  - `a_row_en[0]` high in 7–9; `a_row_en[3]` high in 10–12.
  - `out_valid[0]` high in 12–14; `out_valid[3]` high in 15–17.
  - `done` in cycle 18.
- **N=4, M=0:** `done` in cycle 1. `busy`, `w_rd_en`, `a_rd_en` and `out_valid` stay 0.
- **End-to-end:** weights W = identity (Q7.25 1.0 = 0x02000000), M=2, activations [1,2,3,4] and [5,6,7,8] in Q7.25. Scoreboard: column c outputs the row-c element of each vector, in the `out_valid` windows given above.
- **Busy protection:** `start` re-pulsed in cycles 5 and 18 of an N=4, M=3 run → both ignored; a `start` in cycle 19 → accepted.
- **Mid-tile reset:** `rst` low in cycle 9 of an N=4, M=3 run → all outputs 0 in the same cycle. After release, a fresh start with M=1 → `done` 16 cycles later.
- **Wide tile:** M=300 with N=4 → `a_rd_addr` sweeps 0..299 with no gaps; each `out_valid` bit is high for exactly 300 cycles; `done` at cycle 315.
